// File: rtl/audio_pkg.sv
// Shared audio constants and types for the tone player / detector pair.
// Sample width, delay width and default thresholds live here.
package audio_pkg;

  localparam int AUDIO_W = 32;
  localparam int DELAY_W = 19;
  localparam int CNT_W   = DELAY_W + 1;

  localparam logic signed [AUDIO_W-1:0] THRESH_DEF =
    32'sd100_000_000;
  localparam logic [DELAY_W-1:0] MIN_DELAY_DEF = 19'd10_000;
  localparam logic [DELAY_W-1:0] MAX_DELAY_DEF = 19'd500_000;
  localparam logic [DELAY_W-1:0] TOL_DEF       = 19'd256;

  // Where a sample sits relative to the hysteresis band
  typedef enum logic [1:0] {
    HC_INSIDE = 2'd0,
    HC_ABOVE  = 2'd1,
    HC_BELOW  = 2'd2
  } hyst_t;

  // Magnitude of the difference of two delay values
  function automatic logic [DELAY_W-1:0] abs_diff(
    input logic [DELAY_W-1:0] a,
    input logic [DELAY_W-1:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/tone_period_detector_hyst_classifier.sv
// Classifies a signed sample against a symmetric hysteresis band.
// Equality to either band edge counts as inside.
module hyst_classifier
  import audio_pkg::*;
(
  input  logic signed [AUDIO_W-1:0] sample,
  input  logic signed [AUDIO_W-1:0] thresh,
  output hyst_t                     cls
);

  // Strictly above +thresh or strictly below -thresh
  always_comb begin
    cls = HC_INSIDE;
    if (sample > thresh)
      cls = HC_ABOVE;
    else if (sample < -thresh)
      cls = HC_BELOW;
  end

endmodule

// File: rtl/tone_period_detector.sv
// Measures half-periods of a square tone from microphone samples,
// in CLOCK_50 cycles, with hysteresis, lock and silence flags.
module tone_period_detector
  import audio_pkg::*;
#(
  parameter logic signed [AUDIO_W-1:0] THRESH    = THRESH_DEF,
  parameter logic [DELAY_W-1:0]        MIN_DELAY = MIN_DELAY_DEF,
  parameter logic [DELAY_W-1:0]        MAX_DELAY = MAX_DELAY_DEF,
  parameter logic [DELAY_W-1:0]        TOL       = TOL_DEF
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic                      audio_in_available,
  input  logic signed [AUDIO_W-1:0] left_channel_audio_in,
  output logic                      read_audio_in,
  output logic [DELAY_W-1:0]        half_period,
  output logic                      period_valid,
  output logic                      locked,
  output logic                      silent,
  output logic                      phase
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POS  = 2'd1;
  localparam logic [1:0] S_NEG  = 2'd2;

  // Counter value that means "no crossing for too long"
  localparam logic [CNT_W-1:0] CNT_TO =
    {1'b0, MAX_DELAY} + 20'd1;

  logic signed [AUDIO_W-1:0] sample_q;
  logic                      sample_new;
  hyst_t                     cls;
  logic [1:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [DELAY_W-1:0]        prev;
  logic                      prev_ok;
  logic [DELAY_W-1:0]        meas;
  logic                      timeout;
  logic                      crossing;
  logic                      in_range;
  logic                      close;

  assign read_audio_in = audio_in_available & ~reset;

  // Capture every consumed sample; flag it for one cycle
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sample_q   <= '0;
      sample_new <= 1'b0;
    end else begin
      sample_new <= read_audio_in;
      if (read_audio_in)
        sample_q <= left_channel_audio_in;
    end
  end

  hyst_classifier u_cls (
    .sample (sample_q),
    .thresh (THRESH),
    .cls    (cls)
  );

  assign meas     = cnt[DELAY_W-1:0];
  assign timeout  = (state != S_IDLE) && (cnt == CNT_TO);
  assign crossing = sample_new &&
    (((state == S_POS) && (cls == HC_BELOW)) ||
     ((state == S_NEG) && (cls == HC_ABOVE)));
  assign in_range = (meas >= MIN_DELAY) && (meas <= MAX_DELAY);
  assign close    = abs_diff(meas, prev) <= TOL;
  assign phase    = (state == S_POS);

  // Hysteresis FSM, half-period counter and lock tracking
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      silent       <= 1'b1;
      prev         <= '0;
      prev_ok      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          cnt <= '0;
          if (sample_new && cls == HC_ABOVE)
            state <= S_POS;
          else if (sample_new && cls == HC_BELOW)
            state <= S_NEG;
        end
        timeout: begin
          state  <= S_IDLE;
          cnt    <= '0;
          silent <= 1'b1;
          locked <= 1'b0;
        end
        crossing: begin
          state <= (state == S_POS) ? S_NEG : S_POS;
          cnt   <= '0;
          if (in_range) begin
            half_period  <= meas;
            period_valid <= 1'b1;
            silent       <= 1'b0;
            locked       <= prev_ok & close;
            prev         <= meas;
            prev_ok      <= 1'b1;
          end else begin
            locked  <= 1'b0;
            prev_ok <= 1'b0;
          end
        end
        default: begin
          if (state != S_POS && state != S_NEG) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt != CNT_TO) begin
            cnt <= cnt + 20'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_period_detector.sv
// Randomized scoreboard bench for tone_period_detector.
// Expected outputs come from a timestamp-based reference model.
module tb_tone_period_detector;
  import audio_pkg::*;

  localparam int TMIN = 100;
  localparam int TMAX = 2000;
  localparam int TTOL = 8;
  localparam int TH   = 100_000_000;
  localparam int HI   = 200_000_000;
  localparam int INS  = 50_000_000;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic audio_in_available = 1'b1;
  logic signed [31:0] left_channel_audio_in = '0;
  logic read_audio_in;
  logic [18:0] half_period;
  logic period_valid, locked, silent, phase;

  always #10 CLOCK_50 = ~CLOCK_50;

  tone_period_detector #(
    .THRESH    (32'sd100_000_000),
    .MIN_DELAY (19'(TMIN)),
    .MAX_DELAY (19'(TMAX)),
    .TOL       (19'(TTOL))
  ) dut (
    .CLOCK_50              (CLOCK_50),
    .reset                 (reset),
    .audio_in_available    (audio_in_available),
    .left_channel_audio_in (left_channel_audio_in),
    .read_audio_in         (read_audio_in),
    .half_period           (half_period),
    .period_valid          (period_valid),
    .locked                (locked),
    .silent                (silent),
    .phase                 (phase)
  );

  typedef struct {
    int cyc;
    int hp;
    bit lk;
    bit sil;
    bit ph;
    bit pv;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int n_pv_seen = 0;
  bit exp_read = 1'b0;

  // Reference model: mode 0 unarmed, 1 positive, 2 negative;
  // m_last is the cycle whose edge last restarted timing.
  int m_st = 0;
  int m_last = 0;
  int m_hp = 0;
  int m_prev = 0;
  bit m_lk = 0, m_sil = 1, m_prev_ok = 0, m_pv = 0;
  bit m_new = 0;
  int m_samp = 0;

  always @(posedge CLOCK_50) cyc = cyc + 1;

  task automatic model_cycle(input bit rst);
    int t, el, meas, d;
    bit above, below;
    t = cyc;
    m_pv = 0;
    if (rst) begin
      m_st = 0; m_last = t; m_hp = 0; m_lk = 0;
      m_sil = 1; m_prev_ok = 0; m_prev = 0;
    end else begin
      el = t - m_last - 1;
      above = m_new && (m_samp > TH);
      below = m_new && (m_samp < -TH);
      if (m_st != 0 && el == TMAX + 1) begin
        m_st = 0; m_sil = 1; m_lk = 0; m_last = t;
      end else if (m_st == 0) begin
        if (above) begin m_st = 1; m_last = t; end
        else if (below) begin m_st = 2; m_last = t; end
      end else if ((m_st == 1 && below) ||
                   (m_st == 2 && above)) begin
        meas = el;
        m_st = 3 - m_st;
        m_last = t;
        if (meas >= TMIN && meas <= TMAX) begin
          d = meas - m_prev;
          if (d < 0) d = -d;
          m_lk = m_prev_ok && (d <= TTOL);
          m_prev = meas; m_prev_ok = 1;
          m_hp = meas; m_pv = 1; m_sil = 0;
        end else begin
          m_lk = 0; m_prev_ok = 0;
        end
      end
    end
    sb.push_back('{t + 1, m_hp, m_lk, m_sil, (m_st == 1), m_pv});
  endtask

  task automatic step(input bit rst, input bit av, input int s);
    reset = rst;
    audio_in_available = av;
    left_channel_audio_in = s;
    exp_read = av && !rst;
    model_cycle(rst);
    m_new = av && !rst;
    m_samp = s;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic hold(input int v, input int nsamp, input int sp);
    for (int i = 0; i < nsamp; i++) begin
      step(1'b0, 1'b1, v);
      for (int k = 1; k < sp; k++) step(1'b0, 1'b0, v);
    end
  endtask

  function automatic int rand_amp();
    int r;
    r = 0;
    case ($urandom_range(0, 6))
      0: r = HI;
      1: r = -HI;
      2: r = TH;
      3: r = -TH;
      4: r = TH + 1;
      5: r = -TH - 1;
      default: r = int'($urandom);
    endcase
    return r;
  endfunction

  // Monitor: handshake every cycle, scoreboard entry when due
  always @(negedge CLOCK_50) begin
    exp_t e;
    checks++;
    if (read_audio_in === exp_read) passed++;
    else $display("FAIL read_audio_in cyc=%0d got=%b exp=%b",
                  cyc, read_audio_in, exp_read);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checks++;
      if (half_period === 19'(e.hp) && locked === e.lk &&
          silent === e.sil && phase === e.ph &&
          period_valid === e.pv)
        passed++;
      else
        $display({"FAIL outputs cyc=%0d got hp=%0d pv=%b lk=%b ",
                  "sil=%b ph=%b exp hp=%0d pv=%b lk=%b sil=%b ph=%b"},
                 cyc, half_period, period_valid, locked, silent,
                 phase, e.hp, e.pv, e.lk, e.sil, e.ph);
      if (period_valid === 1'b1) n_pv_seen++;
    end
  end

  initial begin
    @(posedge CLOCK_50);
    #1;
    // reset held with samples offered
    repeat (3) step(1'b1, 1'b1, HI);
    // clean square, 20 samples per half
    for (int i = 0; i < 7; i++) hold((i % 2) ? -HI : HI, 20, 10);
    // inside the band for a long time
    for (int i = 0; i < 60; i++) hold((i % 2) ? -INS : INS, 10, 10);
    // lock, then too-fast flips, then quiet
    for (int i = 0; i < 4; i++) hold((i % 2) ? -HI : HI, 20, 10);
    for (int i = 0; i < 10; i++) hold((i % 2) ? HI : -HI, 5, 10);
    hold(0, 250, 10);
    // 20 then 15 sample halves
    hold(HI, 20, 10); hold(-HI, 20, 10); hold(HI, 20, 10);
    hold(-HI, 15, 10); hold(HI, 15, 10); hold(-HI, 15, 10);
    hold(HI, 5, 10);
    // reset mid-half while locked, then re-arm
    hold(-HI, 20, 10); hold(HI, 20, 10); hold(-HI, 20, 10);
    hold(HI, 10, 10);
    step(1'b1, 1'b1, HI);
    hold(HI, 10, 10); hold(-HI, 20, 10); hold(HI, 20, 10);
    hold(-HI, 20, 10); hold(HI, 3, 10);
    // randomized segments
    for (int s = 0; s < 400; s++) begin
      int v, ns, sp;
      v = rand_amp();
      ns = $urandom_range(1, 25);
      sp = $urandom_range(1, 12);
      if ($urandom_range(0, 99) == 0) step(1'b1, 1'b1, v);
      if ($urandom_range(0, 39) == 0) hold(0, 230, 10);
      for (int i = 0; i < ns; i++) begin
        step(1'b0, 1'b1, v);
        for (int k = 1; k < sp; k++)
          step(1'b0, ($urandom_range(0, 7) == 0), v);
      end
    end
    repeat (4) step(1'b0, 1'b0, 0);
    checks++;
    if (n_pv_seen >= 20) passed++;
    else $display("FAIL pv_count got=%0d exp>=20", n_pv_seen);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
